pwm_gen: RTL and testbench
==========================

Name: pwm_gen

Overview:
Downstream PWM generator for the swerve steering path. Consumes pwm_enable / pwm_ratio / pwm_update from the PWM control block and drives the motor PWM pin. Double-buffers the ratio and applies it only at period boundaries, slew-limited by MAX_STEP per period. Returns a 1-cycle pwm_done pulse once the requested ratio is fully in effect.

Parameters:
PRESCALE, 4, clock cycles per PWM tick (≥1; 1 = tick every clock)
MAX_STEP, 255, max change of active ratio per period boundary (1..255; 255 = immediate)

Ports:
clock  input  1  main clock
reset_n  input  1  reset, asynchronous, active-low
pwm_enable  input  1  level; 1 = run generator, 0 = hold counters, output low
pwm_ratio  input  8  requested high-time out of 255
pwm_update  input  1  capture pwm_ratio this cycle
pwm_done  output  1  1-cycle pulse: requested ratio now active
pwm_out  output  1  PWM waveform to motor driver
period_start  output  1  1-cycle pulse at each period wrap while enabled
active_ratio  output  8  ratio currently applied (debug/status)

Behaviour:
- Reset (async): prc=0, cnt=0, active_ratio=0, pending_ratio=0, pending=0; pwm_out=0, pwm_done=0, period_start=0.
- Prescaler prc counts 0..PRESCALE-1 while enabled; tick = (prc==PRESCALE-1).
- Period counter cnt (8b) advances on tick, 0..254, wraps 254→0 (period = 255 ticks). Boundary = tick && cnt==254.
- pwm_out registered: next = pwm_enable && (cnt < active_ratio). One clock of latency from cnt. Ratio 0 → always low; 255 → always high.
- Capture: any cycle with pwm_update=1 loads pending_ratio<=pwm_ratio, pending<=1. Multi-cycle assertion: last value wins.
- target = pwm_update ? pwm_ratio : pending_ratio (a same-cycle update wins at a boundary).
- At boundary with pending or pwm_update (enabled):
  - diff = |target - active|.
  - If diff ≤ MAX_STEP: active<=target, pending<=0, pwm_done=1 next cycle.
  - Else: active moves MAX_STEP toward target; pending stays 1.
  - Arithmetic is 9-bit; no wrap past 0 or 255.
- New update mid-ramp: target replaced, ramp continues from current active. Exactly one pwm_done, issued when the final target is reached; intermediate targets produce none.
- period_start: registered pulse, 1 clock after each boundary while enabled.
- pwm_enable=0:
  - prc and cnt forced to 0; pwm_out=0 next cycle; period_start=0.
  - A pending or new update is applied directly, without ramp: active<=target, pending<=0, pwm_done pulses the cycle after capture.
- pwm_enable 0→1: counting starts at cnt=0, prc=0 on the first enabled clock.
- pwm_enable dropping mid-ramp: remaining ramp completes immediately per the disabled rule; one pwm_done.
- Reset mid-operation: all state returns to reset values immediately; no pwm_done is emitted for the lost request.
- pwm_done never asserts for two consecutive cycles. It is never asserted without a preceding update.

Test Plan:
- Reset: reset_n=0 for 5 clocks with random inputs -> pwm_out=0, pwm_done=0, period_start=0, active_ratio=0.
- PRESCALE=1, MAX_STEP=255, enable=1, update ratio=64 -> one pwm_done 1 clock after the next boundary (≤256 clocks); thereafter pwm_out high exactly 64 of every 255 clocks; period_start every 255 clocks.
- Extremes: ratio=0 -> pwm_out constantly 0; ratio=255 -> pwm_out constantly 1 across 3 periods; pwm_done once per update.
- Ramp, MAX_STEP=16, active 0, update 64 -> active_ratio 16, 32, 48, 64 on four successive boundaries; single pwm_done after the 4th.
- Retarget mid-ramp to 20 after active=32, MAX_STEP=16 -> next boundary active=20; exactly one pwm_done.
- Disabled update: enable=0, update ratio=200 -> active_ratio=200 and pwm_done 1 clock later; pwm_out stays 0.
- Update on the exact boundary cycle, ratio=100 (MAX_STEP=255) -> active=100 at that boundary, pwm_done next clock.
- reset_n pulsed low mid-ramp -> active=0, no pwm_done.

Source files
------------

// File: rtl/pwm_gen.sv
// PWM generator with double-buffered ratio, applied at period boundaries
// under a per-period slew limit; pwm_done pulses once the request is in effect.
module pwm_gen #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned MAX_STEP = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_update,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       period_start,
  output logic [7:0] active_ratio
);

  localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRC_LAST = PW'(PRESCALE - 1);
  localparam logic [8:0]     STEP     = 9'(MAX_STEP);
  localparam logic [7:0]     CNT_LAST = 8'd254;

  logic [PW-1:0] prc;
  logic [7:0]    cnt;
  logic [7:0]    pending_ratio;
  logic          pending;

  logic          tick;
  logic          boundary;
  logic          apply;
  logic          final_step;
  logic [7:0]    target;
  logic [7:0]    next_active;
  logic [8:0]    diff;

  always_comb begin
    tick       = pwm_enable && (prc == PRC_LAST);
    boundary   = tick && (cnt == CNT_LAST);
    target     = pwm_update ? pwm_ratio : pending_ratio;
    apply      = (pending || pwm_update) && (!pwm_enable || boundary);
    if (target >= active_ratio)
      diff = {1'b0, target} - {1'b0, active_ratio};
    else
      diff = {1'b0, active_ratio} - {1'b0, target};
    // Disabled updates bypass the slew limit entirely.
    final_step = !pwm_enable || (diff <= STEP);
    if (final_step)
      next_active = target;
    else if (target > active_ratio)
      next_active = 8'({1'b0, active_ratio} + STEP);
    else
      next_active = 8'({1'b0, active_ratio} - STEP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prc           <= '0;
      cnt           <= '0;
      active_ratio  <= '0;
      pending_ratio <= '0;
      pending       <= 1'b0;
      pwm_out       <= 1'b0;
      pwm_done      <= 1'b0;
      period_start  <= 1'b0;
    end else begin
      if (!pwm_enable) begin
        prc <= '0;
        cnt <= '0;
      end else if (tick) begin
        prc <= '0;
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 8'd1;
      end else begin
        prc <= prc + PW'(1);
      end

      pwm_out      <= pwm_enable && (cnt < active_ratio);
      period_start <= boundary;
      pwm_done     <= 1'b0;

      if (pwm_update) begin
        pending_ratio <= pwm_ratio;
        pending       <= 1'b1;
      end

      // Completion clears pending even if an update arrives in the same cycle,
      // since that update is the target being applied. A held update cannot
      // produce back-to-back done pulses.
      if (apply) begin
        active_ratio <= next_active;
        if (final_step) begin
          pending  <= 1'b0;
          pwm_done <= !pwm_done;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: dut_a (PRESCALE=1, MAX_STEP=255) for waveform and
// boundary timing, dut_b (PRESCALE=2, MAX_STEP=16) for ramp, retarget and disable.
module tb_pwm_gen;

  logic       clock;
  logic       rst_a, en_a, upd_a, done_a, out_a, ps_a;
  logic [7:0] ratio_a, act_a;
  logic       rst_b, en_b, upd_b, done_b, out_b, ps_b;
  logic [7:0] ratio_b, act_b;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  pwm_gen #(.PRESCALE(1), .MAX_STEP(255)) dut_a (
    .clock(clock), .reset_n(rst_a), .pwm_enable(en_a), .pwm_ratio(ratio_a),
    .pwm_update(upd_a), .pwm_done(done_a), .pwm_out(out_a),
    .period_start(ps_a), .active_ratio(act_a)
  );

  pwm_gen #(.PRESCALE(2), .MAX_STEP(16)) dut_b (
    .clock(clock), .reset_n(rst_b), .pwm_enable(en_b), .pwm_ratio(ratio_b),
    .pwm_update(upd_b), .pwm_done(done_b), .pwm_out(out_b),
    .period_start(ps_b), .active_ratio(act_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic       upd;
    logic [7:0] ratio;
    logic [7:0] exp_act;
    logic       exp_done;
  } vec_t;

  function automatic logic get_done(input int w);
    return (w == 0) ? done_a : done_b;
  endfunction

  function automatic logic get_ps(input int w);
    return (w == 0) ? ps_a : ps_b;
  endfunction

  function automatic logic get_out(input int w);
    return (w == 0) ? out_a : out_b;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (get_done(0) === 1'b1 && 1'b0) done_cnt = done_cnt;
  endtask

  // Steps until pwm_done (want_done=1) or period_start, counting done pulses.
  task automatic wait_ev(input string name, input int w, input bit want_done,
                         input int bound, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < bound) begin
      @(negedge clock);
      n++;
      if (get_done(w)) done_cnt++;
      if (want_done ? get_done(w) : get_ps(w)) found = 1'b1;
    end
    chk({name, "_seen"}, int'(found), 1);
  endtask

  task automatic window(input int w, input int len, output int highs,
                        output int ps_n, output int done_n);
    highs = 0; ps_n = 0; done_n = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      if (get_out(w))  highs++;
      if (get_ps(w))   ps_n++;
      if (get_done(w)) done_n++;
    end
  endtask

  initial begin
    vec_t tbl[7];
    int   n, highs, ps_n, done_n, bad;

    tbl[0] = '{1'b1, 8'd10,  8'd10,  1'b1};
    tbl[1] = '{1'b0, 8'd99,  8'd10,  1'b0};
    tbl[2] = '{1'b1, 8'd250, 8'd250, 1'b1};
    tbl[3] = '{1'b1, 8'd5,   8'd5,   1'b0};
    tbl[4] = '{1'b0, 8'd77,  8'd5,   1'b0};
    tbl[5] = '{1'b0, 8'd0,   8'd5,   1'b0};
    tbl[6] = '{1'b1, 8'd0,   8'd0,   1'b1};

    // Reset with random inputs
    rst_a = 1'b0; rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en_a = 1'($urandom_range(0, 1)); upd_a = 1'($urandom_range(0, 1));
      ratio_a = 8'($urandom_range(0, 255));
      en_b = 1'($urandom_range(0, 1)); upd_b = 1'($urandom_range(0, 1));
      ratio_b = 8'($urandom_range(0, 255));
      @(negedge clock);
    end
    chk("rst_a_out", int'(out_a), 0);
    chk("rst_a_done", int'(done_a), 0);
    chk("rst_a_ps", int'(ps_a), 0);
    chk("rst_a_act", int'(act_a), 0);
    chk("rst_b_out", int'(out_b), 0);
    chk("rst_b_done", int'(done_b), 0);
    chk("rst_b_ps", int'(ps_b), 0);
    chk("rst_b_act", int'(act_b), 0);
    en_a = 1'b0; upd_a = 1'b0; ratio_a = '0;
    en_b = 1'b0; upd_b = 1'b0; ratio_b = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clock);

    // dut_a: ratio 64 lands at the first boundary, 255 clocks after enabling
    en_a = 1'b1; upd_a = 1'b1; ratio_a = 8'd64;
    @(negedge clock);
    upd_a = 1'b0;
    wait_ev("a64_done", 0, 1'b1, 300, n);
    chk("a64_latency", n + 1, 255);
    chk("a64_ps_with_done", int'(ps_a), 1);
    chk("a64_act", int'(act_a), 64);
    window(0, 255, highs, ps_n, done_n);
    chk("a64_highs", highs, 64);
    chk("a64_ps_count", ps_n, 1);
    chk("a64_extra_done", done_n, 0);

    // dut_a: extremes
    upd_a = 1'b1; ratio_a = 8'd0;
    @(negedge clock);
    upd_a = 1'b0;
    done_cnt = 0;
    wait_ev("a0_done", 0, 1'b1, 300, n);
    window(0, 765, highs, ps_n, done_n);
    chk("a0_highs", highs, 0);
    chk("a0_ps_count", ps_n, 3);
    chk("a0_dones", done_cnt + done_n, 1);
    upd_a = 1'b1; ratio_a = 8'd255;
    @(negedge clock);
    upd_a = 1'b0;
    done_cnt = 0;
    wait_ev("a255_done", 0, 1'b1, 300, n);
    window(0, 765, highs, ps_n, done_n);
    chk("a255_highs", highs, 765);
    chk("a255_dones", done_cnt + done_n, 1);

    // dut_a: update on the exact boundary cycle overrides an earlier pending one
    wait_ev("a_sync_ps", 0, 1'b0, 300, n);
    for (int j = 1; j <= 254; j++) begin
      @(negedge clock);
      upd_a   = (j == 10) || (j == 254);
      ratio_a = (j == 254) ? 8'd100 : 8'd30;
      if (j == 254) chk("ab_act_before", int'(act_a), 255);
    end
    @(negedge clock);
    upd_a = 1'b0;
    chk("ab_act", int'(act_a), 100);
    chk("ab_done", int'(done_a), 1);
    chk("ab_ps", int'(ps_a), 1);
    @(negedge clock);
    chk("ab_done_single", int'(done_a), 0);

    // dut_a: disabled update is applied directly
    en_a = 1'b0;
    repeat (2) @(negedge clock);
    upd_a = 1'b1; ratio_a = 8'd200;
    @(negedge clock);
    upd_a = 1'b0;
    chk("ad_act", int'(act_a), 200);
    chk("ad_done", int'(done_a), 1);
    window(0, 10, highs, ps_n, done_n);
    chk("ad_out_low", highs + ps_n, 0);
    chk("ad_done_once", done_n, 0);

    // dut_b: ramp 0 -> 64 in steps of 16
    en_b = 1'b1; upd_b = 1'b1; ratio_b = 8'd64;
    @(negedge clock);
    upd_b = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ev("ramp_ps", 1, 1'b0, 600, n);
      chk("ramp_act", int'(act_b), 16 * (i + 1));
      chk("ramp_done_here", int'(done_b), (i == 3) ? 1 : 0);
    end
    chk("ramp_done_total", done_cnt, 1);

    // dut_b: disabled table, including a held update that must not double-pulse done
    en_b = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      upd_b = tbl[i].upd; ratio_b = tbl[i].ratio;
      @(negedge clock);
      chk("tbl_act", int'(act_b), int'(tbl[i].exp_act));
      chk("tbl_done", int'(done_b), int'(tbl[i].exp_done));
      chk("tbl_out", int'(out_b), 0);
    end
    upd_b = 1'b0;

    // dut_b: retarget mid-ramp
    en_b = 1'b1; upd_b = 1'b1; ratio_b = 8'd64;
    @(negedge clock);
    upd_b = 1'b0;
    done_cnt = 0;
    wait_ev("rt_ps1", 1, 1'b0, 600, n);
    chk("rt_act16", int'(act_b), 16);
    wait_ev("rt_ps2", 1, 1'b0, 600, n);
    chk("rt_act32", int'(act_b), 32);
    upd_b = 1'b1; ratio_b = 8'd20;
    @(negedge clock);
    upd_b = 1'b0;
    wait_ev("rt_ps3", 1, 1'b0, 600, n);
    chk("rt_act20", int'(act_b), 20);
    chk("rt_done", int'(done_b), 1);
    chk("rt_done_total", done_cnt, 1);

    // dut_b: enable dropped mid-ramp finishes the ramp at once
    upd_b = 1'b1; ratio_b = 8'd200;
    @(negedge clock);
    upd_b = 1'b0;
    done_cnt = 0;
    wait_ev("ed_ps", 1, 1'b0, 600, n);
    chk("ed_act36", int'(act_b), 36);
    en_b = 1'b0;
    @(negedge clock);
    chk("ed_act", int'(act_b), 200);
    chk("ed_done", int'(done_b), 1);
    chk("ed_out", int'(out_b), 0);
    chk("ed_ps", int'(ps_b), 0);
    @(negedge clock);
    chk("ed_done_single", int'(done_b) + done_cnt, 0);

    // dut_b: reset mid-ramp discards the request
    en_b = 1'b1; upd_b = 1'b1; ratio_b = 8'd100;
    @(negedge clock);
    upd_b = 1'b0;
    wait_ev("rr_ps", 1, 1'b0, 600, n);
    chk("rr_act184", int'(act_b), 184);
    rst_b = 1'b0;
    #1;
    chk("rr_act", int'(act_b), 0);
    chk("rr_done", int'(done_b), 0);
    @(negedge clock);
    rst_b = 1'b1;
    window(1, 600, highs, ps_n, done_n);
    bad = (act_b != 8'd0) ? 1 : 0;
    chk("rr_no_done", done_n, 0);
    chk("rr_ps_after", ps_n, 1);
    chk("rr_act_stays", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
